hd_trace_recorder: RTL
======================

# hd_trace_recorder

Switching-activity recorder for simulation-based TVLA. It sits beside a gate-level netlist built from the behavioural cell library. It samples a probe bus of internal nets every clock and computes the Hamming distance between successive samples. Those distances are summed over a fixed window of cycles, and each window sum is streamed out as one leakage-trace point through a small FIFO with a valid/ready handshake.

## Interface
Parameters:
- WIDTH, 128, number of probed nets
- WIN, 4, clock cycles accumulated per trace point (≥1)
- DEPTH, 8, output FIFO entries (power of two, ≥2)

Ports:
- CLK  in  1  clock; all state on rising edge
- R  in  1  reset, asynchronous, active-low
- START  in  1  one-cycle request to begin a capture; honoured only in IDLE
- NSAMP  in  16  number of trace points to capture; sampled on accepted START
- PROBE  in  WIDTH  netlist nets under observation
- OUT_READY  in  1  consumer ready
- OUT_VALID  out  1  OUT_DATA holds a trace point
- OUT_DATA  out  SW  trace point, SW = $clog2(WIDTH*WIN+1)
- BUSY  out  1  high in every state except IDLE
- DONE  out  1  one-cycle pulse when a capture completes
- OVF  out  1  sticky flag: at least one trace point was dropped because the FIFO was full

## Operation
- States: IDLE, PRIME, CAPTURE, DRAIN.
- **IDLE**
  - START=1 latches NSAMP, clears OVF, accumulator, window counter and sample counter.
  - Transitions to PRIME.
- **PRIME** (exactly 1 cycle)
  - prev <= PROBE; no distance is computed.
  - If NSAMP=0, go to DRAIN; otherwise go to CAPTURE.
- **CAPTURE**, every cycle:
  - hd = popcount(PROBE ^ prev); prev <= PROBE.
  - If wcnt < WIN-1: acc <= acc+hd, wcnt++.
  - If wcnt = WIN-1: push acc+hd to the FIFO, acc <= 0, wcnt <= 0, scnt++.
  - After the push that makes scnt = NSAMP, go to DRAIN.
- **DRAIN**: stay until the FIFO is empty, then pulse DONE and go to IDLE.
- **Arithmetic**: all values are unsigned. acc is SW bits wide and cannot overflow, since its maximum is WIDTH*WIN.
- **FIFO full at push**
  - The trace point is dropped and OVF is set.
  - scnt still increments; capture never stalls.
  - If a pop happens in the same cycle, the push is accepted.
- **Handshake**
  - A transfer occurs when OUT_VALID & OUT_READY.
  - OUT_DATA and OUT_VALID are stable while OUT_READY is low.
  - OUT_VALID = FIFO not empty.
- START outside IDLE is ignored.
- **R low at any time**
  - All state returns to IDLE and the FIFO empties; in-flight points are lost.
  - Outputs are OUT_VALID=0, OUT_DATA=0, BUSY=0, DONE=0, OVF=0.

## Timing
- The START cycle is edge 0. The PRIME edge is 1. CAPTURE edges are 2..WIN+1 for the first window.
- A point is pushed on the last edge of its window. OUT_VALID rises in the following cycle, giving 1 cycle of latency from window close.
- Output data is registered in the FIFO; there is no combinational path from PROBE to OUT_DATA.
- DONE pulses one cycle after the FIFO becomes empty in DRAIN. With NSAMP=0, DONE pulses 3 cycles after START.
- BUSY rises the cycle after START and falls with the DONE cycle.

## Configuration
- Macro: HD_TRACE_HW_MODE_EN.
- **Defined**
  - Adds input MODE (1 bit), sampled on START.
  - MODE=1 selects Hamming-weight leakage: hd = popcount(PROBE), and prev is unused.
  - MODE=0 selects Hamming distance, as above.
- **Undefined**
  - No MODE port; Hamming distance only.
  - Area is identical apart from the mux.

## Structure
- Package hd_trace_pkg holds:
  - the state enum (IDLE, PRIME, CAPTURE, DRAIN);
  - a function for SW width computation;
  - the localparam for the NSAMP width (16).
- Sub-module hd_popcount (parameter WIDTH) is a pure combinational adder tree producing $clog2(WIDTH+1) bits.
- The FIFO is inline: a register array with read/write pointers and a count.

## Test plan
All scenarios use WIDTH=8, WIN=4, DEPTH=4.
- **Constant probe:** PROBE=8'h00 constant, NSAMP=3, OUT_READY=1 -> three points of 0, then DONE, OVF=0.
- **Full toggle:** PROBE alternates 8'h00/8'hFF each cycle, NSAMP=2, OUT_READY=1 -> points 32, 32; BUSY falls with DONE.
- **Back-pressure overflow:** alternating probe, NSAMP=6, OUT_READY=0 until DRAIN.
  - OVF rises on the 5th push.
  - Then OUT_READY=1 -> exactly four points of 32 read, then DONE.
- **Reset mid-capture:** R pulled low in CAPTURE with points queued -> OUT_VALID=0, BUSY=0, OVF=0 immediately (asynchronous). A new START with NSAMP=1 then yields one correct point.
- **Ignored START and empty capture:**
  - START pulsed while BUSY -> no effect.
  - START with NSAMP=0 -> DONE 3 cycles later, no OUT_VALID.
- **Weight mode (HD_TRACE_HW_MODE_EN defined):** MODE=1, PROBE=8'h0F constant, NSAMP=1 -> point 16. With MODE=0 the same stimulus gives 0.

Source files
------------

// File: rtl/hd_trace_pkg.sv
// rtl/hd_trace_pkg.sv - shared state type, NSAMP width and trace-point width helper
package hd_trace_pkg;

  localparam int NSAMP_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRIME,
    ST_CAPTURE,
    ST_DRAIN
  } state_t;

  // A window sum reaches WIDTH*WIN, so the point needs room for that value inclusive
  function automatic int sw_width(input int width, input int win);
    return $clog2(width * win + 1);
  endfunction

endpackage

// File: rtl/hd_trace_recorder_if.sv
// rtl/hd_trace_recorder_if.sv - trace-point output stream between recorder and consumer
interface hd_trace_recorder_if #(
  parameter int WIDTH = 128,
  parameter int WIN   = 4
);
  localparam int SW = hd_trace_pkg::sw_width(WIDTH, WIN);

  logic          OUT_VALID;
  logic          OUT_READY;
  logic [SW-1:0] OUT_DATA;

  modport master (output OUT_VALID, output OUT_DATA, input OUT_READY);
  modport slave  (input OUT_VALID, input OUT_DATA, output OUT_READY);
endinterface

// File: rtl/hd_popcount.sv
// rtl/hd_popcount.sv - combinational population count built as a balanced adder tree
module hd_popcount #(
  parameter int WIDTH = 128
) (
  input  logic [WIDTH-1:0]           in_bits,
  output logic [$clog2(WIDTH+1)-1:0] cnt
);
  localparam int CW = $clog2(WIDTH + 1);

  if (WIDTH == 1) begin : g_leaf
    assign cnt = in_bits;
  end else begin : g_node
    localparam int LW = WIDTH / 2;
    localparam int HW = WIDTH - LW;

    logic [$clog2(LW+1)-1:0] lo_cnt;
    logic [$clog2(HW+1)-1:0] hi_cnt;

    hd_popcount #(.WIDTH(LW)) u_lo (.in_bits(in_bits[LW-1:0]),     .cnt(lo_cnt));
    hd_popcount #(.WIDTH(HW)) u_hi (.in_bits(in_bits[WIDTH-1:LW]), .cnt(hi_cnt));

    assign cnt = CW'(lo_cnt) + CW'(hi_cnt);
  end
endmodule

// File: rtl/hd_trace_recorder.sv
// rtl/hd_trace_recorder.sv - windowed Hamming-distance recorder with output FIFO
// HD_TRACE_HW_MODE_EN adds a MODE input selecting Hamming-weight leakage.
module hd_trace_recorder
  import hd_trace_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int WIN   = 4,
  parameter int DEPTH = 8
) (
  input  logic                CLK,
  input  logic                R,
  input  logic                START,
  input  logic [NSAMP_W-1:0]  NSAMP,
  input  logic [WIDTH-1:0]    PROBE,
`ifdef HD_TRACE_HW_MODE_EN
  input  logic                MODE,
`endif
  output logic                BUSY,
  output logic                DONE,
  output logic                OVF,
  hd_trace_recorder_if.master out_if
);
  localparam int SW  = sw_width(WIDTH, WIN);
  localparam int CW  = $clog2(WIDTH + 1);
  localparam int AW  = $clog2(DEPTH);
  localparam int WCW = (WIN > 1) ? $clog2(WIN) : 1;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   prev_q, prev_d;
  logic [SW-1:0]      acc_q, acc_d;
  logic [WCW-1:0]     wcnt_q, wcnt_d;
  logic [NSAMP_W-1:0] scnt_q, scnt_d;
  logic [NSAMP_W-1:0] nsamp_q, nsamp_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;
  logic [SW-1:0]      mem_q [DEPTH];
  logic [AW-1:0]      wptr_q, wptr_d;
  logic [AW-1:0]      rptr_q, rptr_d;
  logic [AW:0]        cnt_q, cnt_d;
`ifdef HD_TRACE_HW_MODE_EN
  logic               mode_q, mode_d;
`endif

  logic [WIDTH-1:0]   probe_x;
  logic [CW-1:0]      hd;
  logic [SW-1:0]      point;
  logic [NSAMP_W-1:0] scnt_inc;
  logic               push, pop, full, wr_en;

  always_comb begin
    probe_x = PROBE ^ prev_q;
`ifdef HD_TRACE_HW_MODE_EN
    if (mode_q) probe_x = PROBE;
`endif
  end

  hd_popcount #(.WIDTH(WIDTH)) u_popcount (.in_bits(probe_x), .cnt(hd));

  assign point    = acc_q + SW'(hd);
  assign scnt_inc = scnt_q + NSAMP_W'(1);
  assign full     = (cnt_q == (AW+1)'(DEPTH));
  assign pop      = out_if.OUT_VALID & out_if.OUT_READY;
  // A full FIFO still takes the point when the consumer frees a slot this cycle
  assign wr_en    = push & (~full | pop);

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    acc_d   = acc_q;
    wcnt_d  = wcnt_q;
    scnt_d  = scnt_q;
    nsamp_d = nsamp_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    push    = 1'b0;
`ifdef HD_TRACE_HW_MODE_EN
    mode_d  = mode_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          nsamp_d = NSAMP;
          ovf_d   = 1'b0;
          acc_d   = '0;
          wcnt_d  = '0;
          scnt_d  = '0;
`ifdef HD_TRACE_HW_MODE_EN
          mode_d  = MODE;
`endif
          state_d = ST_PRIME;
        end
      end
      ST_PRIME: begin
        prev_d  = PROBE;
        state_d = (nsamp_q == '0) ? ST_DRAIN : ST_CAPTURE;
      end
      ST_CAPTURE: begin
        prev_d = PROBE;
        if (wcnt_q == WCW'(WIN - 1)) begin
          push   = 1'b1;
          acc_d  = '0;
          wcnt_d = '0;
          scnt_d = scnt_inc;
          if (scnt_inc == nsamp_q) state_d = ST_DRAIN;
        end else begin
          acc_d  = point;
          wcnt_d = wcnt_q + WCW'(1);
        end
      end
      ST_DRAIN: begin
        if (cnt_q == '0) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (push && !wr_en) ovf_d = 1'b1;

    wptr_d = wr_en ? wptr_q + AW'(1) : wptr_q;
    rptr_d = pop ? rptr_q + AW'(1) : rptr_q;
    case ({wr_en, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      state_q <= ST_IDLE;
      prev_q  <= '0;
      acc_q   <= '0;
      wcnt_q  <= '0;
      scnt_q  <= '0;
      nsamp_q <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
`ifdef HD_TRACE_HW_MODE_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      acc_q   <= acc_d;
      wcnt_q  <= wcnt_d;
      scnt_q  <= scnt_d;
      nsamp_q <= nsamp_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
`ifdef HD_TRACE_HW_MODE_EN
      mode_q  <= mode_d;
`endif
    end
  end

  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wptr_q] <= point;
    end
  end

  assign out_if.OUT_VALID = (cnt_q != '0);
  assign out_if.OUT_DATA  = out_if.OUT_VALID ? mem_q[rptr_q] : '0;
  assign BUSY             = (state_q != ST_IDLE);
  assign DONE             = done_q;
  assign OVF              = ovf_q;

endmodule
